// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the execute stage and a simple
// request/acknowledge memory port. It handles byte, half and word accesses,
// drives lane-replicated store data with byte enables, and returns sign- or
// zero-extended load data. Misaligned accesses and bus timeouts are reported
// as sticky flags that apply to the most recent access.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [1:0]  whb,
    input  logic        su,
    output logic [31:0] read_data,
    output logic        done,
    output logic        busy,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam int unsigned CW       = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t       r_state, w_next;
    logic [6:0]   r_opcode;
    logic [31:0]  r_addr;
    logic [31:0]  r_sdata;
    logic [1:0]   r_whb;
    logic         r_su;
    logic [CW-1:0] r_count;
    logic [31:0]  r_read_data;
    logic         r_misaligned;
    logic         r_bus_err;

    logic w_in_mem, w_in_misal, w_accept, w_ack_ok, w_timeout;
    logic w_r_load, w_r_store;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [3:0]  w_store_be;
    logic [31:0] w_store_data;

    // Decode of the access presented this cycle (used only when accepting)
    always_comb begin
        w_in_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
        w_in_misal = 1'b0;
        case (whb)
            2'b00:   w_in_misal = 1'b0;
            2'b01:   w_in_misal = addr[0];
            default: w_in_misal = (addr[1:0] != 2'b00);
        endcase
    end

    // Next-state logic and transition qualifiers
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_ack_ok  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (w_in_mem && !w_in_misal) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                // ack on the final wait cycle still completes normally
                if (mem_ack) begin
                    w_ack_ok = 1'b1;
                    w_next   = S_DONE;
                end else if (r_count == CW'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane selection and extension of returned load data
    always_comb begin
        w_r_load  = (r_opcode == OP_LOAD);
        w_r_store = (r_opcode == OP_STORE);
        case (r_addr[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_whb)
            2'b00:   w_load_ext = {{24{r_su & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{r_su & w_half[15]}}, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        case (r_whb)
            2'b00: begin
                w_store_be   = 4'b0001 << r_addr[1:0];
                w_store_data = {4{r_sdata[7:0]}};
            end
            2'b01: begin
                w_store_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{r_sdata[15:0]}};
            end
            default: begin
                w_store_be   = 4'b1111;
                w_store_data = r_sdata;
            end
        endcase
    end

    // State register, access latch, wait counter, result and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_opcode     <= '0;
            r_addr       <= '0;
            r_sdata      <= '0;
            r_whb        <= '0;
            r_su         <= 1'b0;
            r_count      <= '0;
            r_read_data  <= '0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_opcode     <= opcode;
                r_addr       <= addr;
                r_sdata      <= store_data;
                r_whb        <= whb;
                r_su         <= su;
                r_count      <= '0;
                r_misaligned <= w_in_mem && w_in_misal;
                r_bus_err    <= 1'b0;
            end else if (r_state == S_REQ && !mem_ack) begin
                r_count <= r_count + CW'(1);
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
            if (w_ack_ok && w_r_load) begin
                r_read_data <= w_load_ext;
            end
        end
    end

    // Output drive derived from state and the latched access
    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        mem_req    = (r_state == S_REQ);
        mem_we     = mem_req && w_r_store;
        mem_be     = mem_req ? (w_r_store ? w_store_be : 4'b1111) : 4'b0000;
        mem_addr   = {r_addr[31:2], 2'b00};
        mem_wdata  = w_store_data;
        read_data  = r_read_data;
        misaligned = r_misaligned;
        bus_err    = r_bus_err;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of accesses with expected results
// pushed to a scoreboard on issue and compared when done pulses, plus
// hand-written sequences for reset, busy-start and stray-ack cases.
module tb_mem_access_unit;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0010011;
    localparam int unsigned NOACK = 255;

    logic        clk = 1'b0;
    logic        rst, start, su, mem_ack;
    logic [6:0]  opcode;
    logic [31:0] addr, store_data, mem_rdata;
    logic [1:0]  whb;
    logic [31:0] read_data, mem_addr, mem_wdata;
    logic        done, busy, misaligned, bus_err, mem_req, mem_we;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [1:0]  whb;
        logic        su;
        logic [31:0] rdata;
        int unsigned wait_n;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_mis;
        logic        e_berr;
        int unsigned e_lat;
        int unsigned e_reqs;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .addr       (addr),
        .store_data (store_data),
        .whb        (whb),
        .su         (su),
        .read_data  (read_data),
        .done       (done),
        .busy       (busy),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " read_data"}, read_data, 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " misaligned"}, 32'(misaligned), 32'h0);
        chk({tag, " bus_err"}, 32'(bus_err), 32'h0);
        chk({tag, " mem_req"}, 32'(mem_req), 32'h0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, " mem_be"}, 32'(mem_be), 32'h0);
        chk({tag, " mem_addr"}, mem_addr, 32'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Issue one access, answer the memory port, score the result on done
    task automatic do_access(input vec_t v, input int idx);
        int unsigned cyc;
        int unsigned reqs;
        bit fin;
        vec_t e;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        opcode = v.op; addr = v.addr; store_data = v.sdata;
        whb = v.whb; su = v.su; start = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; reqs = 0; fin = 1'b0;
        while (!fin && cyc < 40) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                chk({p, " mem_addr"}, mem_addr, v.e_addr);
                chk({p, " mem_we"}, 32'(mem_we), 32'(v.e_we));
                chk({p, " mem_be"}, 32'(mem_be), 32'(v.e_be));
                if (v.e_we) chk({p, " mem_wdata"}, mem_wdata, v.e_wdata);
                if (reqs == v.wait_n) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                end
                reqs++;
            end
            if (done) begin
                fin = 1'b1;
                if (sb.size() == 0) begin
                    chk({p, " scoreboard empty"}, 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({p, " read_data"}, read_data, e.e_rd);
                    chk({p, " misaligned"}, 32'(misaligned), 32'(e.e_mis));
                    chk({p, " bus_err"}, 32'(bus_err), 32'(e.e_berr));
                    chk({p, " latency"}, cyc, e.e_lat);
                    chk({p, " req_cycles"}, reqs, e.e_reqs);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        if (!fin) chk({p, " done timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        //           op   addr          sdata         whb  su  rdata         wait   e_addr        we  be       e_wdata       e_rd          mis  berr lat reqs
        vecs[0]  = '{LD,  32'h0000_0103, 32'h0,         2'b00, 1, 32'h80FF_FF00, 0,     32'h0000_0100, 0, 4'b1111, 32'h0,         32'hFFFF_FF80, 0, 0, 2,  1};
        vecs[1]  = '{ST,  32'h0000_0202, 32'h1234_ABCD, 2'b01, 0, 32'h0,         0,     32'h0000_0200, 1, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, 0, 0, 2,  1};
        vecs[2]  = '{LD,  32'h0000_0101, 32'h0,         2'b10, 0, 32'h0,         0,     32'h0,         0, 4'b1111, 32'h0,         32'hFFFF_FF80, 1, 0, 1,  0};
        vecs[3]  = '{LD,  32'h0000_0102, 32'h0,         2'b01, 0, 32'hBEEF_1234, 3,     32'h0000_0100, 0, 4'b1111, 32'h0,         32'h0000_BEEF, 0, 0, 5,  4};
        vecs[4]  = '{LD,  32'h0000_0001, 32'h0,         2'b00, 0, 32'h0000_A500, 0,     32'h0000_0000, 0, 4'b1111, 32'h0,         32'h0000_00A5, 0, 0, 2,  1};
        vecs[5]  = '{ST,  32'h0000_0003, 32'hAABB_CC77, 2'b00, 0, 32'h0,         0,     32'h0000_0000, 1, 4'b1000, 32'h7777_7777, 32'h0000_00A5, 0, 0, 2,  1};
        vecs[6]  = '{ST,  32'h0000_0008, 32'hDEAD_BEEF, 2'b11, 0, 32'h0,         0,     32'h0000_0008, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_00A5, 0, 0, 2,  1};
        vecs[7]  = '{ALU, 32'h0000_0010, 32'h0,         2'b10, 0, 32'h0,         0,     32'h0,         0, 4'b1111, 32'h0,         32'h0000_00A5, 0, 0, 1,  0};
        vecs[8]  = '{LD,  32'h0000_0040, 32'h0,         2'b10, 0, 32'h0,         NOACK, 32'h0000_0040, 0, 4'b1111, 32'h0,         32'h0000_00A5, 0, 1, 17, 16};
        vecs[9]  = '{LD,  32'h0000_0044, 32'h0,         2'b01, 1, 32'h1234_8001, 15,    32'h0000_0044, 0, 4'b1111, 32'h0,         32'hFFFF_8001, 0, 0, 17, 16};
        vecs[10] = '{ST,  32'h0000_0045, 32'h0,         2'b01, 0, 32'h0,         0,     32'h0,         0, 4'b1111, 32'h0,         32'hFFFF_8001, 1, 0, 1,  0};
        vecs[11] = '{LD,  32'h0000_0048, 32'h0,         2'b10, 0, 32'hCAFE_F00D, 1,     32'h0000_0048, 0, 4'b1111, 32'h0,         32'hCAFE_F00D, 0, 0, 3,  2};
        vecs[12] = '{LD,  32'h0000_004A, 32'h0,         2'b00, 1, 32'h007F_0000, 0,     32'h0000_0048, 0, 4'b1111, 32'h0,         32'h0000_007F, 0, 0, 2,  1};

        rst = 1'b1; start = 1'b0; opcode = '0; addr = '0; store_data = '0;
        whb = '0; su = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // stray ack while idle
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle ack busy", 32'(busy), 32'h0);
        chk("idle ack done", 32'(done), 32'h0);
        chk("idle ack read_data", read_data, 32'h0);

        for (int i = 0; i < 13; i++) do_access(vecs[i], i);

        // start held high while busy: store request must be ignored
        @(negedge clk);
        opcode = LD; addr = 32'h50; whb = 2'b10; su = 1'b0; start = 1'b1;
        @(negedge clk);
        opcode = ST; addr = 32'h80; store_data = 32'h0;
        chk("busy-start req", 32'(mem_req), 32'h1);
        chk("busy-start we", 32'(mem_we), 32'h0);
        @(negedge clk);
        chk("busy-start addr", mem_addr, 32'h50);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("busy-start done", 32'(done), 32'h1);
        start = 1'b0;
        @(negedge clk);
        chk("busy-start idle", 32'(busy), 32'h0);
        chk("busy-start read_data", read_data, 32'h1111_2222);

        // reset in the middle of a request, then a late ack
        @(negedge clk);
        opcode = LD; addr = 32'h60; whb = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst-mid req", 32'(mem_req), 32'h1);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_reset_outputs("rst-mid");
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late ack done", 32'(done), 32'h0);
        chk("late ack busy", 32'(busy), 32'h0);
        chk("late ack read_data", read_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles spent in REQ without mem_ack before a bus error.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: execute stage presents an access this cycle.
REQ-005 The block SHALL have port opcode, input, 7 bits: instruction opcode; 0000011 = load, 0100011 = store.
REQ-006 The block SHALL have port addr, input, 32 bits: effective byte address (ALU result).
REQ-007 The block SHALL have port store_data, input, 32 bits: rs2 value for stores.
REQ-008 The block SHALL have port whb, input, 2 bits: access size; 00 = byte, 01 = half, 10 = word, 11 = treated as word.
REQ-009 The block SHALL have port su, input, 1 bit: 1 = sign-extend loads, 0 = zero-extend.
REQ-010 The block SHALL have port read_data, output, 32 bits: extended load result, consumed by write-back.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The block SHALL have port misaligned, output, 1 bit: sticky flag for the last access; set if that access was misaligned.
REQ-014 The block SHALL have port bus_err, output, 1 bit: sticky flag for the last access; set if that access timed out.
REQ-015 The block SHALL have port mem_req, output, 1 bit: memory request.
REQ-016 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-017 The block SHALL have port mem_addr, output, 32 bits: word-aligned address, {addr[31:2], 2'b00}.
REQ-018 The block SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-019 The block SHALL have port mem_be, output, 4 bits: byte enables.
REQ-020 The block SHALL have port mem_rdata, input, 32 bits: memory read data, valid with mem_ack.
REQ-021 The block SHALL have port mem_ack, input, 1 bit: memory completes the request this cycle.

Function
REQ-022 The FSM SHALL have states IDLE, REQ and DONE.
REQ-023 In IDLE with start=1, the block SHALL latch opcode, addr, store_data, whb and su, then decide as follows:
- Aligned load or store: next state REQ.
- Any other opcode, or a misaligned access: next state DONE, with no bus request.
REQ-024 Misaligned SHALL mean: half with addr[0]=1, or word with addr[1:0]!=00; misaligned is set on entry to DONE.
REQ-025 In REQ, mem_req SHALL be 1, and mem_addr/mem_we/mem_be/mem_wdata SHALL be held stable until mem_ack.
REQ-026 Store byte enables and data SHALL be:
- Byte: mem_be = 0001 << addr[1:0], mem_wdata = {4{d[7:0]}}.
- Half: mem_be = 0011 or 1100 by addr[1], mem_wdata = {2{d[15:0]}}.
- Word: mem_be = 1111.
REQ-027 Loads SHALL drive mem_we=0 and mem_be=1111.
REQ-028 When mem_ack=1 in REQ, the next state SHALL be DONE, and for loads read_data SHALL register the selected lane (byte lane addr[1:0], half lane addr[1]), extended per su.
REQ-029 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; reaching TIMEOUT SHALL go to DONE, deassert mem_req and set bus_err.
REQ-030 mem_ack in the same cycle as the counter reaching TIMEOUT SHALL win: normal completion, bus_err=0.
REQ-031 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a completed load therefore reports done 2 cycles after start with zero-wait memory.
REQ-032 start while busy=1 (including in DONE) SHALL be ignored.
REQ-033 read_data SHALL hold its value between accesses; stores, non-memory opcodes, misaligned accesses and timeouts SHALL leave it unchanged.
REQ-034 misaligned and bus_err SHALL clear on the next accepted start.
REQ-035 mem_ack outside REQ SHALL be ignored.

Reset
REQ-036 With rst=1 at a clock edge, the block SHALL go to IDLE, clear the counter, and drive read_data=0, done=0, busy=0, misaligned=0, bus_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset during REQ SHALL drop mem_req at that edge; a late mem_ack SHALL have no effect.

Verification
REQ-038 Load byte: opcode=0000011, addr=0x103, whb=00, su=1, mem_rdata=0x80FF_FF00, ack on first REQ cycle -> mem_addr=0x100, read_data=0xFFFF_FF80, done at cycle 2.
REQ-039 Store half: opcode=0100011, addr=0x202, whb=01, store_data=0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD.
REQ-040 Misaligned word: addr=0x101, whb=10 -> no mem_req, misaligned=1, done pulse, read_data unchanged.
REQ-041 Timeout: load with mem_ack held 0 -> mem_req high for 16 cycles, then bus_err=1 and done pulse.
REQ-042 Non-memory opcode 0010011 -> done one cycle after start, no mem_req.
REQ-043 Reset mid-REQ followed by mem_ack=1 -> mem_req=0, no done, all outputs at reset values.
